// File: rtl/mlp_core.sv
// Two-layer fixed-point perceptron: one MAC per cycle, ReLU hidden layer.
// Define MLP_SATURATE_EN for clamping narrowing; otherwise results wrap.
module mlp_core #(
    parameter int NUM_FEATURES  = 4,
    parameter int NUM_CLASSES   = 3,
    parameter int FP_TOTAL_BITS = 16,
    parameter int FP_FRAC_BITS  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic signed [FP_TOTAL_BITS-1:0] x [NUM_FEATURES],
    input  logic signed [FP_TOTAL_BITS-1:0] hidden_bias [NUM_FEATURES],
    input  logic signed [FP_TOTAL_BITS-1:0]
        hidden_weights [NUM_FEATURES][NUM_FEATURES],
    input  logic signed [FP_TOTAL_BITS-1:0] out_bias [NUM_CLASSES],
    input  logic signed [FP_TOTAL_BITS-1:0]
        out_weights [NUM_FEATURES][NUM_CLASSES],
    output logic signed [FP_TOTAL_BITS-1:0] mlp_out [NUM_CLASSES],
    output logic done
);

    localparam int NF = NUM_FEATURES;
    localparam int NC = NUM_CLASSES;
    localparam int W = FP_TOTAL_BITS;
    localparam int F = FP_FRAC_BITS;
    localparam int ACC_W = 2 * W + $clog2(NF) + 1;
    localparam int NMAX = (NF > NC) ? NF : NC;
    localparam int IW = (NF > 1) ? $clog2(NF) : 1;
    localparam int OW = (NMAX > 1) ? $clog2(NMAX) : 1;

    localparam logic [IW-1:0] IN_LAST = IW'(NF - 1);
    localparam logic [OW-1:0] HID_LAST = OW'(NF - 1);
    localparam logic [OW-1:0] CLS_LAST = OW'(NC - 1);

    typedef enum logic [1:0] {
        IDLE,
        HID,
        OUT,
        DONE
    } state_t;

    state_t state;

    logic signed [W-1:0] xr [NF];
    logic signed [W-1:0] h [NF];
    logic signed [ACC_W-1:0] acc;
    logic [IW-1:0] in_idx;
    logic [OW-1:0] out_idx;

    logic signed [W-1:0] opa;
    logic signed [W-1:0] opb;
    logic signed [W-1:0] bias;
    logic signed [2*W-1:0] prod;
    logic signed [ACC_W-1:0] prod_x;
    logic signed [ACC_W-1:0] bias_x;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] act;
    logic signed [W-1:0] narrow;

    // Operand mux: the same MAC serves both layers.
    always_comb begin
        opa = '0;
        opb = '0;
        bias = '0;
        if (state == OUT) begin
            opa = h[in_idx];
            opb = out_weights[in_idx][out_idx];
            bias = out_bias[out_idx];
        end else begin
            opa = xr[in_idx];
            opb = hidden_weights[in_idx][out_idx];
            bias = hidden_bias[out_idx];
        end
    end

    assign prod = opa * opb;
    assign prod_x = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    assign bias_x = {{(ACC_W-W){bias[W-1]}}, bias};
    assign sum = acc + prod_x;
    assign biased = sum + (bias_x <<< F);
    assign shifted = biased >>> F;
    assign act = (state == HID && shifted < 0) ? '0 : shifted;

`ifdef MLP_SATURATE_EN
    localparam logic signed [ACC_W-1:0] MAX_V =
        {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    always_comb begin
        narrow = act[W-1:0];
        if (act > MAX_V) begin
            narrow = {1'b0, {(W-1){1'b1}}};
        end else if (act < MIN_V) begin
            narrow = {1'b1, {(W-1){1'b0}}};
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^act[ACC_W-1:W];
    assign narrow = act[W-1:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done <= 1'b0;
            acc <= '0;
            in_idx <= '0;
            out_idx <= '0;
            for (int i = 0; i < NF; i++) begin
                xr[i] <= '0;
                h[i] <= '0;
            end
            for (int k = 0; k < NC; k++) begin
                mlp_out[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (state == DONE) begin
                        done <= 1'b1;
                    end
                    if (start) begin
                        xr <= x;
                        done <= 1'b0;
                        acc <= '0;
                        in_idx <= '0;
                        out_idx <= '0;
                        state <= HID;
                    end
                end
                HID: begin
                    if (in_idx == IN_LAST) begin
                        h[out_idx[IW-1:0]] <= narrow;
                        acc <= '0;
                        in_idx <= '0;
                        if (out_idx == HID_LAST) begin
                            out_idx <= '0;
                            state <= OUT;
                        end else begin
                            out_idx <= out_idx + OW'(1);
                        end
                    end else begin
                        acc <= sum;
                        in_idx <= in_idx + IW'(1);
                    end
                end
                OUT: begin
                    if (in_idx == IN_LAST) begin
                        mlp_out[out_idx] <= narrow;
                        acc <= '0;
                        in_idx <= '0;
                        if (out_idx == CLS_LAST) begin
                            out_idx <= '0;
                            state <= DONE;
                        end else begin
                            out_idx <= out_idx + OW'(1);
                        end
                    end else begin
                        acc <= sum;
                        in_idx <= in_idx + IW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_core.sv
// Scoreboard bench for mlp_core: stimulus pushes model results,
// a monitor pops and compares them when done rises.
module tb_mlp_core;

    localparam int NF = 4;
    localparam int NC = 3;
    localparam int W = 16;
    localparam int F = 8;
    localparam int LAT = NF * NF + NF * NC + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic signed [W-1:0] x_s [NF];
    logic signed [W-1:0] hb_s [NF];
    logic signed [W-1:0] hw_s [NF][NF];
    logic signed [W-1:0] ob_s [NC];
    logic signed [W-1:0] ow_s [NF][NC];
    logic signed [W-1:0] out_s [NC];
    logic done;

    typedef struct packed {
        logic [NC-1:0][W-1:0] v;
        int unsigned edge_n;
    } exp_t;

    exp_t sb[$];
    int unsigned cyc = 0;
    logic st_q = 1'b0;
    int total = 0;
    int bad = 0;

    mlp_core dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .x(x_s),
        .hidden_bias(hb_s),
        .hidden_weights(hw_s),
        .out_bias(ob_s),
        .out_weights(ow_s),
        .mlp_out(out_s),
        .done(done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        st_q <= start;
    end

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, want, cyc);
        end
    endtask

    function automatic longint narrow_ref(input longint v);
        logic signed [W-1:0] t;
`ifdef MLP_SATURATE_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        t = W'(v);
        return longint'(t);
`endif
    endfunction

    // Reference: plain dot products, bias scaled by 2^F, floor division.
    function automatic logic [NC-1:0][W-1:0] model();
        longint h[NF];
        longint s;
        logic [NC-1:0][W-1:0] r;
        for (int j = 0; j < NF; j++) begin
            s = 0;
            for (int i = 0; i < NF; i++)
                s += longint'(x_s[i]) * longint'(hw_s[i][j]);
            s += longint'(hb_s[j]) * (64'sd1 <<< F);
            s = s >>> F;
            if (s < 0) s = 0;
            h[j] = narrow_ref(s);
        end
        for (int k = 0; k < NC; k++) begin
            s = 0;
            for (int j = 0; j < NF; j++)
                s += h[j] * longint'(ow_s[j][k]);
            s += longint'(ob_s[k]) * (64'sd1 <<< F);
            s = s >>> F;
            r[k] = W'(narrow_ref(s));
        end
        return r;
    endfunction

    task automatic clear_all();
        for (int i = 0; i < NF; i++) begin
            x_s[i] = '0;
            hb_s[i] = '0;
            for (int j = 0; j < NF; j++) hw_s[i][j] = '0;
            for (int k = 0; k < NC; k++) ow_s[i][k] = '0;
        end
        for (int k = 0; k < NC; k++) ob_s[k] = '0;
    endtask

    task automatic identity();
        clear_all();
        for (int i = 0; i < NF; i++) hw_s[i][i] = 16'sh0100;
        for (int k = 0; k < NC; k++) ow_s[k][k] = 16'sh0100;
    endtask

    task automatic set_x(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d);
        x_s[0] = a;
        x_s[1] = b;
        x_s[2] = c;
        x_s[3] = d;
    endtask

    task automatic run(input bit expect_it);
        exp_t e;
        @(negedge clk);
        e.v = model();
        e.edge_n = cyc + 1;
        start = 1'b1;
        if (expect_it) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic settle();
        repeat (LAT + 4) @(negedge clk);
    endtask

    function automatic logic [W-1:0] rnd(input bit wide);
        if (wide) return W'($urandom);
        return W'($urandom_range(0, 1023)) - 16'd512;
    endfunction

    // Monitor
    initial begin
        exp_t cur;
        bit have;
        bit prev_done;
        have = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_done", {15'b0, done}, 16'h0);
                for (int k = 0; k < NC; k++)
                    chk("rst_out", out_s[k], 16'h0);
                have = 1'b0;
            end else begin
                if (prev_done)
                    chk("done_level", {15'b0, done}, {15'b0, !st_q});
                if (done && !prev_done) begin
                    chk("sb_pending", {15'b0, sb.size() > 0}, 16'h1);
                    if (sb.size() > 0) begin
                        cur = sb.pop_front();
                        have = 1'b1;
                        chk("latency", 16'(cyc - cur.edge_n), 16'(LAT));
                        for (int k = 0; k < NC; k++)
                            chk("result", out_s[k], cur.v[k]);
                    end
                end else if (done && have) begin
                    for (int k = 0; k < NC; k++)
                        chk("hold", out_s[k], cur.v[k]);
                end
                if (sb.size() > 0 &&
                    int'(cyc) - int'(sb[0].edge_n) > LAT + 3) begin
                    total++;
                    bad++;
                    $display("FAIL timeout: done low, want high by %0d",
                             sb[0].edge_n + LAT);
                    void'(sb.pop_front());
                end
            end
            prev_done = done;
        end
    end

    // Stimulus
    initial begin
        clear_all();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        identity();
        set_x(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        run(1);
        settle();

        identity();
        hw_s[1][1] = 16'sh0080;
        set_x(16'hFF00, 16'h0080, 16'h0200, 16'h0000);
        run(1);
        settle();

        clear_all();
        ob_s[0] = 16'sh0080;
        ob_s[1] = -16'sh0080;
        ob_s[2] = 16'sh0000;
        run(1);
        settle();

        identity();
        for (int i = 0; i < NF; i++) begin
            x_s[i] = 16'sh7F00;
            for (int j = 0; j < NF; j++) hw_s[i][j] = 16'sh7F00;
        end
        run(1);
        settle();

        identity();
        set_x(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        run(0);
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        run(1);
        settle();

        run(1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        settle();

        set_x(16'h0040, 16'hFE00, 16'h0180, 16'h0300);
        run(1);
        settle();

        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < NF; i++) begin
                x_s[i] = rnd(it[0]);
                hb_s[i] = rnd(it[0]);
                for (int j = 0; j < NF; j++) hw_s[i][j] = rnd(it[0]);
                for (int k = 0; k < NC; k++) ow_s[i][k] = rnd(it[0]);
            end
            for (int k = 0; k < NC; k++) ob_s[k] = rnd(it[0]);
            run(1);
            settle();
        end

        for (int t = 0; t < 200 && sb.size() > 0; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mlp_core.md
Name: mlp_core

Overview:
- Fixed-point two-layer perceptron inference engine: input vector → fully-connected hidden layer with ReLU → fully-connected output layer (linear, no activation).
- Produces one signed score per class; downstream logic takes the arg-max as the predicted class.
- Sequential single-MAC datapath. Weights and biases arrive on parallel array ports from a host/loader. Inference is triggered by a start pulse and signalled complete by a held done level.

Parameters:
- NUM_FEATURES, 4: number of inputs; also the number of hidden neurons.
- NUM_CLASSES, 3: number of output neurons.
- FP_TOTAL_BITS, 16: total width of every signed fixed-point value.
- FP_FRAC_BITS, 8: fractional bits. Default format is Q8.8, so 1.0 = 0x0100.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  inference request; acted on only in IDLE or DONE.
- x  in  signed [FP_TOTAL_BITS] x NUM_FEATURES  input features.
- hidden_bias  in  signed [FP_TOTAL_BITS] x NUM_FEATURES  hidden bias per neuron j.
- hidden_weights  in  signed [FP_TOTAL_BITS] x NUM_FEATURES x NUM_FEATURES  element [i][j] = weight from input i to hidden j.
- out_bias  in  signed [FP_TOTAL_BITS] x NUM_CLASSES  output bias per class k.
- out_weights  in  signed [FP_TOTAL_BITS] x NUM_FEATURES x NUM_CLASSES  element [j][k] = weight from hidden j to class k.
- mlp_out  out  signed [FP_TOTAL_BITS] x NUM_CLASSES  class scores.
- done  out  1  result valid; held high.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - Abort any computation; state = IDLE.
  - done = 0; mlp_out all 0; hidden registers and accumulator = 0.
- FSM states: IDLE, HID, OUT, DONE.
- IDLE or DONE, start = 1 at a clock edge:
  - Latch x into internal registers.
  - Clear done and the accumulator.
  - Set indices to 0; go to HID.
- start in HID or OUT is ignored.
- Weights and biases are read combinationally during computation and must be held stable from start until done.
- Accumulator width: 2*FP_TOTAL_BITS + clog2(NUM_FEATURES) + 1 bits, signed.
- HID state:
  - For each hidden neuron j (outer loop) and input i (inner loop), one MAC per cycle: acc += x[i] * hidden_weights[i][j] (full-precision product).
  - On the cycle of the last i: value = (acc + (hidden_bias[j] << FP_FRAC_BITS)) >>> FP_FRAC_BITS (arithmetic shift, truncates toward −inf); apply ReLU (negative → 0); narrow to FP_TOTAL_BITS; store as h[j]; clear acc.
  - Duration: NUM_FEATURES*NUM_FEATURES cycles; then go to OUT.
- OUT state:
  - Same procedure for each class k over hidden j: acc += h[j] * out_weights[j][k]; add out_bias[k] the same way.
  - No ReLU.
  - Narrowed result is written to mlp_out[k].
  - Duration: NUM_FEATURES*NUM_CLASSES cycles; then go to DONE.
- DONE state:
  - done = 1; mlp_out holds until the next accepted start or reset.
  - Each mlp_out element updates once per inference and is stable whenever done = 1.
- Latency: done rises NUM_FEATURES*NUM_FEATURES + NUM_FEATURES*NUM_CLASSES + 1 rising edges after the edge that sampled start (29 with defaults).
- Narrowing: saturating or wrapping, selected per Optional Feature.
- Simultaneous reset and start: reset wins.

Optional Feature:
- Macro MLP_SATURATE_EN.
- Defined: narrowing clamps to the range [−2^(FP_TOTAL_BITS−1), 2^(FP_TOTAL_BITS−1)−1], i.e. 0x8000..0x7FFF for defaults.
- Undefined: narrowing keeps the low FP_TOTAL_BITS bits (two's-complement wrap).
- Latency, handshake and all other behaviour are identical either way.

Test Plan:
1. Identity path: hidden_weights[i][j] = 0x0100 if i==j else 0; out_weights[j][k] = 0x0100 if j==k else 0; all biases 0; x = {0x0100, 0x0200, 0x0300, 0x0400}; pulse start → done rises exactly 29 cycles later; mlp_out = {0x0100, 0x0200, 0x0300}; done stays 1.
2. ReLU and fraction: same weights as scenario 1; x = {0xFF00, 0x0080, 0x0200, 0}; diagonal hidden weight of input 1 = 0x0080 → h[0] = 0 (ReLU); mlp_out = {0x0000, 0x0040, 0x0200}.
3. Bias only: all weights 0; out_bias = {0x0080, 0xFF80, 0x0000} → mlp_out = {0x0080, 0xFF80, 0x0000}, so arg-max = class 0.
4. Overflow: x all 0x7F00; hidden_weights all 0x7F00; identity out_weights; biases 0 → with MLP_SATURATE_EN, mlp_out = {0x7FFF, 0x7FFF, 0x7FFF}; without it, mlp_out equals the truncated low 16 bits.
5. Reset mid-operation: assert reset 10 cycles after start → done = 0 and mlp_out = 0 immediately; release, re-run scenario 1 → same results and latency.
6. Handshake: start pulsed again during HID → ignored, result and latency unchanged; start asserted in DONE with new x → done drops next cycle, new result appears 29 cycles after that start.
